// File: rtl/rotate_sequencer.sv
// rtl/rotate_sequencer.sv - clocked single-bit rotator with a START/BUSY/DONE handshake
// Rotates Q one position per clock, COUNT times, in the direction sampled with START.
module rotate_sequencer #(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          LOAD,
   input  logic [N-1:0]  DIN,
   input  logic          START,
   input  logic          DIR,
   input  logic [CW-1:0] COUNT,
   output logic [N-1:0]  Q,
   output logic          BUSY,
   output logic          DONE
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t        state_q;
   logic [N-1:0]  q_q;
   logic [N-1:0]  q_d;
   logic [CW-1:0] rem_q;
   logic          dir_q;
   logic          busy_q;
   logic          done_q;

   // One-position rotation of the register in the latched direction (1 = right).
   always_comb begin
      q_d = q_q;
      if (dir_q) begin
         q_d = {q_q[0], q_q[N-1:1]};
      end else begin
         q_d = {q_q[N-2:0], q_q[N-1]};
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         q_q     <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (LOAD) begin
                  q_q <= DIN;
               end else if (START) begin
                  dir_q <= DIR;
                  rem_q <= COUNT;
                  if (COUNT == '0) begin
                     state_q <= FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               q_q   <= q_d;
               rem_q <= rem_q - 1'b1;
               // Last rotation is applied on the same edge that leaves RUN.
               if (rem_q == CW'(1)) begin
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// tb/tb_rotate_sequencer.sv - directed vector bench for rotate_sequencer
module tb_rotate_sequencer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       LOAD = 1'b0;
   logic [7:0] DIN = 8'h00;
   logic       START = 1'b0;
   logic       DIR = 1'b0;
   logic [7:0] COUNT = 8'h00;
   logic [7:0] Q;
   logic       BUSY;
   logic       DONE;

   int n_checks = 0;
   int n_fails  = 0;

   rotate_sequencer #(.N(8), .CW(8)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .LOAD  (LOAD),
      .DIN   (DIN),
      .START (START),
      .DIR   (DIR),
      .COUNT (COUNT),
      .Q     (Q),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       load;
      logic [7:0] din;
      logic       start;
      logic       dir;
      logic [7:0] cnt;
      logic [7:0] exp_q;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      LOAD = 1'b0; START = 1'b0; DIN = 8'h00; DIR = 1'b0; COUNT = 8'h00;
   endtask

   task automatic load_val(input logic [7:0] v);
      LOAD = 1'b1; DIN = v;
      step();
      idle_inputs();
   endtask

   // Issue START, count BUSY cycles (bounded), then check final Q and DONE pulse.
   task automatic run_req(input string nm, input logic d, input logic [7:0] k,
                          input logic [7:0] exp_q, input int exp_cycles);
      int n;
      START = 1'b1; DIR = d; COUNT = k;
      step();
      idle_inputs();
      n = 0;
      while (BUSY && n < 1000) begin
         n++;
         DIR = ~DIR;
         step();
      end
      idle_inputs();
      chk({nm, "_busy_cycles"}, n, exp_cycles);
      chk({nm, "_q"}, Q, exp_q);
      chk({nm, "_done"}, DONE, 1'b1);
      step();
      chk({nm, "_done_clr"}, DONE, 1'b0);
   endtask

   initial begin
      logic [7:0] rseq [8];
      rseq = '{8'h56, 8'h2B, 8'h95, 8'hCA, 8'h65, 8'hB2, 8'h59, 8'hAC};

      //          load din    st  dir cnt    q      busy done
      vecs[0]  = '{1'b1, 8'hAC, 1'b0, 1'b0, 8'd0, 8'hAC, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd1, 8'hAC, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h56, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h56, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'hAC, 1'b0, 1'b0, 8'd0, 8'hAC, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 8'hAC, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 8'h33, 1'b1, 1'b1, 8'd7, 8'h59, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'd0, 8'hB2, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'h65, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd2, 8'h65, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h65, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 8'h65, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h65, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 8'hF0, 1'b1, 1'b1, 8'd4, 8'hF0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'hF0, 1'b0, 1'b0};

      RESET = 1'b1;
      step();
      step();
      chk("reset_q", Q, 8'h00);
      chk("reset_busy", BUSY, 1'b0);
      chk("reset_done", DONE, 1'b0);
      RESET = 1'b0;

      for (int i = 0; i < 15; i++) begin
         LOAD = vecs[i].load; DIN = vecs[i].din; START = vecs[i].start;
         DIR = vecs[i].dir; COUNT = vecs[i].cnt;
         step();
         chk($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
         chk($sformatf("vec%0d_busy", i), BUSY, vecs[i].exp_busy);
         chk($sformatf("vec%0d_done", i), DONE, vecs[i].exp_done);
      end
      idle_inputs();

      // Full-width right rotation, per-cycle Q, with stray LOAD/START pulses during RUN.
      load_val(8'hAC);
      START = 1'b1; DIR = 1'b1; COUNT = 8'd8;
      step();
      chk("r8_busy_start", BUSY, 1'b1);
      for (int i = 0; i < 8; i++) begin
         LOAD = i[0]; START = ~i[0]; DIN = 8'hFF; DIR = 1'b0; COUNT = 8'd2;
         step();
         chk($sformatf("r8_q%0d", i), Q, rseq[i]);
         chk($sformatf("r8_busy%0d", i), BUSY, (i < 7) ? 1'b1 : 1'b0);
      end
      chk("r8_done", DONE, 1'b1);
      LOAD = 1'b1; DIN = 8'h11; START = 1'b0;
      step();
      idle_inputs();
      chk("r8_finish_load_ignored", Q, 8'hAC);
      chk("r8_done_clr", DONE, 1'b0);

      load_val(8'hAC);
      run_req("l3", 1'b0, 8'd3, 8'h65, 3);
      load_val(8'hAC);
      run_req("l11", 1'b0, 8'd11, 8'h65, 11);
      load_val(8'hAC);
      run_req("r255", 1'b1, 8'd255, 8'h59, 255);

      // Reset with remaining == 5 aborts the request without a DONE pulse.
      load_val(8'hAC);
      START = 1'b1; DIR = 1'b1; COUNT = 8'd8;
      step();
      idle_inputs();
      step();
      step();
      step();
      chk("abort_pre_q", Q, 8'h95);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      chk("abort_q", Q, 8'h00);
      chk("abort_busy", BUSY, 1'b0);
      chk("abort_done", DONE, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("abort_nodone%0d", i), DONE, 1'b0);
         chk($sformatf("abort_nobusy%0d", i), BUSY, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
